// File: rtl/add_round_key_stage_pkg.sv
// Shared AES-128 definitions: data types, S-box, and GF(2^8) helpers.
// Imported by the AddRoundKey stage and by the key schedule step.
package add_round_key_stage_pkg;

  typedef logic [127:0] state_t;
  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    ST_NOKEY,
    ST_RUN
  } ark_state_e;

  // Element 0 is the leftmost byte, so SBOX[b] is the substitution of b.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]),
            sub_byte(w[15:8]),  sub_byte(w[7:0])};
  endfunction

  // Multiply by 2 in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/add_round_key_stage_key_schedule_step.sv
// One AES-128 key expansion step: derives round key N+1 from round key N.
// Purely combinational so it can be shared with a decryption key expander.
module key_schedule_step
  import add_round_key_stage_pkg::*;
(
  input  key_t       round_key,
  input  logic [7:0] rcon,
  output key_t       next_key
);

  word_t w0, w1, w2, w3;
  word_t t;
  word_t n0, n1, n2, n3;

  always_comb begin
    w0 = round_key[127:96];
    w1 = round_key[95:64];
    w2 = round_key[63:32];
    w3 = round_key[31:0];
    // RotWord then SubWord, then fold the round constant into the top byte.
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage with an on-the-fly round key generator that
// advances one round per accepted transfer and wraps after the last round.
module add_round_key_stage
  import add_round_key_stage_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter logic [7:0]  RCON_INIT  = add_round_key_stage_pkg::RCON_INIT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  state_t       in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output state_t       out_state,
  output logic [3:0]   out_round,
  output logic         key_valid
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ark_state_e state_q, state_d;
  key_t       cipher_key_q, cipher_key_d;
  key_t       round_key_q, round_key_d;
  logic [7:0] rcon_q, rcon_d;
  logic [3:0] round_q, round_d;
  logic       out_valid_q, out_valid_d;
  state_t     out_state_q, out_state_d;
  logic [3:0] out_round_q, out_round_d;

  key_t next_key;
  logic accept;

  key_schedule_step u_key_step (
    .round_key (round_key_q),
    .rcon      (rcon_q),
    .next_key  (next_key)
  );

  always_comb begin
    state_d = state_q;
    if (key_load) begin
      state_d = ST_RUN;
    end
  end

  assign key_valid = (state_q == ST_RUN);
  assign in_ready  = key_valid && !key_load && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;

  // key_load takes priority over an accept; in_ready already masks it.
  always_comb begin
    cipher_key_d = cipher_key_q;
    round_key_d  = round_key_q;
    rcon_d       = rcon_q;
    round_d      = round_q;
    if (key_load) begin
      cipher_key_d = key_in;
      round_key_d  = key_in;
      rcon_d       = RCON_INIT;
      round_d      = '0;
    end else if (accept) begin
      if (round_q == LAST_ROUND) begin
        round_key_d = cipher_key_q;
        rcon_d      = RCON_INIT;
        round_d     = '0;
      end else begin
        round_key_d = next_key;
        rcon_d      = gf_xtime(rcon_q);
        round_d     = round_q + 4'd1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;
    out_round_d = out_round_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_state_d = in_state ^ round_key_q;
      out_round_d = round_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_NOKEY;
      cipher_key_q <= '0;
      round_key_q  <= '0;
      rcon_q       <= RCON_INIT;
      round_q      <= '0;
      out_valid_q  <= 1'b0;
      out_state_q  <= '0;
      out_round_q  <= '0;
    end else begin
      state_q      <= state_d;
      cipher_key_q <= cipher_key_d;
      round_key_q  <= round_key_d;
      rcon_q       <= rcon_d;
      round_q      <= round_d;
      out_valid_q  <= out_valid_d;
      out_state_q  <= out_state_d;
      out_round_q  <= out_round_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_round = out_round_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Scoreboard bench for add_round_key_stage using FIPS-197 key expansion vectors.
module tb_add_round_key_stage;

  logic         clock = 1'b0;
  logic         reset;
  logic         key_load;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         key_valid;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [127:0] st;
    logic [3:0]   rnd;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  add_round_key_stage #(
    .NUM_ROUNDS (10),
    .RCON_INIT  (8'h01)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_round (out_round),
    .key_valid (key_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer completes on the coming edge when valid and ready are both high.
  initial begin
    forever begin
      @(negedge clock);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_output: got %h round %0d, expected none", out_state, out_round);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_state", out_state, e.st);
          check("out_round", 128'(out_round), 128'(e.rnd));
        end
      end
    end
  end

  // Callers are aligned to 1 time unit after a rising edge.
  task automatic send(input logic [127:0] s, input logic push,
                      input logic [127:0] es, input logic [3:0] er);
    int cycles;
    exp_t e;
    in_valid = 1'b1;
    in_state = s;
    cycles = 0;
    @(negedge clock);
    while (!in_ready && cycles < 50) begin
      @(negedge clock);
      cycles++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", cycles);
    end else if (push) begin
      e.st  = es;
      e.rnd = er;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1;
    key_in   = k;
    @(posedge clock);
    #1;
    key_load = 1'b0;
  endtask

  initial begin
    int wait_cycles;
    reset     = 1'b1;
    key_load  = 1'b0;
    key_in    = '0;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    @(negedge clock);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_state", out_state, '0);
    check("rst_out_round", 128'(out_round), 128'(0));
    check("rst_key_valid", 128'(key_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    @(posedge clock);
    #1;

    // No key loaded: input must be refused.
    in_valid = 1'b1;
    in_state = 128'h3243f6a8885a308d313198a2e0370734;
    repeat (10) begin
      @(negedge clock);
      check("nokey_in_ready", 128'(in_ready), 128'(0));
      check("nokey_out_valid", 128'(out_valid), 128'(0));
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;

    load_key(KEY_A);
    @(negedge clock);
    check("key_valid_set", 128'(key_valid), 128'(1));
    @(posedge clock);
    #1;
    send(128'h3243f6a8885a308d313198a2e0370734, 1'b1,
         128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0);

    // Full round cycle plus wrap back to the cipher key.
    load_key(KEY_A);
    for (int unsigned i = 0; i < 12; i++) begin
      send('0, 1'b1, RK[i % 11], 4'(i % 11));
    end
    @(posedge clock);
    #1;

    // Backpressure hold on round 1.
    out_ready = 1'b0;
    send('0, 1'b1, RK[1], 4'd1);
    in_valid = 1'b1;
    in_state = '0;
    repeat (5) begin
      @(negedge clock);
      check("hold_out_valid", 128'(out_valid), 128'(1));
      check("hold_out_state", out_state, RK[1]);
      check("hold_out_round", 128'(out_round), 128'(1));
      check("hold_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    send('0, 1'b1, RK[2], 4'd2);
    send('0, 1'b1, RK[3], 4'd3);

    // key_load collides with in_valid at round 4.
    key_load = 1'b1;
    key_in   = KEY_B;
    in_valid = 1'b1;
    in_state = '0;
    @(negedge clock);
    check("kl_in_ready", 128'(in_ready), 128'(0));
    @(posedge clock);
    #1;
    key_load = 1'b0;
    in_valid = 1'b0;
    send('0, 1'b1, KEY_B, 4'd0);
    send('0, 1'b1, KEY_B_R1, 4'd1);

    // Reset with an output pending at round 7.
    load_key(KEY_A);
    for (int unsigned i = 0; i < 7; i++) begin
      send('0, 1'b1, RK[i], 4'(i));
    end
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    send('0, 1'b0, '0, 4'd0);
    @(negedge clock);
    check("r7_out_valid", 128'(out_valid), 128'(1));
    check("r7_out_state", out_state, RK[7]);
    check("r7_out_round", 128'(out_round), 128'(7));
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    in_valid = 1'b1;
    in_state = '0;
    @(negedge clock);
    check("rst2_out_valid", 128'(out_valid), 128'(0));
    check("rst2_key_valid", 128'(key_valid), 128'(0));
    check("rst2_out_state", out_state, '0);
    repeat (3) begin
      check("rst2_in_ready", 128'(in_ready), 128'(0));
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    load_key(KEY_A);
    @(negedge clock);
    check("reload_in_ready", 128'(in_ready), 128'(1));
    @(posedge clock);
    #1;
    send('0, 1'b1, RK[0], 4'd0);
    send('0, 1'b1, RK[1], 4'd1);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 20) begin
      @(posedge clock);
      wait_cycles++;
    end
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
Sequential AddRoundKey stage for AES-128 encryption; consumes the state produced by MixColumns (or the initial plaintext / final ShiftRows state) and XORs it with the current round key. Holds the cipher key and generates each round key on the fly, advancing one round per accepted transfer. Sits at the end of each round in the iterative datapath. Output goes to the next round's SubBytes or to the ciphertext port.

Parameters:
NUM_ROUNDS, 10, last round index; round counter runs 0..NUM_ROUNDS and then wraps to 0.
RCON_INIT, 8'h01, Rcon value used for round 1.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
key_load  input  1  load key_in as the cipher key (round key 0).
key_in  input  128  cipher key; bits [127:120] are byte 0.
in_valid  input  1  in_state is valid.
in_ready  output  1  stage can accept in_state this cycle.
in_state  input  state_t  16-byte state; byte 0 corresponds to bits [127:120].
out_valid  output  1  out_state is valid.
out_ready  input  1  downstream accepts out_state.
out_state  output  state_t  in_state XOR current round key, registered.
out_round  output  4  round index used for out_state.
key_valid  output  1  a cipher key has been loaded since reset.

Behaviour:
- Reset values: out_valid=0, out_state=0, out_round=0, key_valid=0, round counter=0, Rcon=RCON_INIT, round key=0. In-flight output is discarded. Reset overrides every other input.
- FSM states:
  - NOKEY (after reset): in_ready=0.
  - key_load moves NOKEY to RUN.
  - RUN stays in RUN; key_load in RUN reloads the key.
- in_ready = key_valid && !key_load && (!out_valid || out_ready).
- Accept: in_valid && in_ready. On the next edge:
  - out_state <= in_state ^ round_key.
  - out_round <= round counter.
  - out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid. Full throughput is one transfer per cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, out_state and out_round are stable and in_ready=0. out_valid clears on out_ready with no new accept.
- Key advance on accept:
  - If counter < NUM_ROUNDS: counter+1; round_key <= next_key(round_key, Rcon); Rcon <= xtime(Rcon).
  - If counter == NUM_ROUNDS: counter <= 0; round_key <= stored cipher key; Rcon <= RCON_INIT.
- next_key: t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'. Words are key bytes 0-3, 4-7, 8-11, 12-15.
- Rcon is multiplied by 2 in GF(2^8) with reduction polynomial 0x1B, giving 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- key_load (in NOKEY or RUN):
  - Stores key_in as the cipher key and loads it as the round key.
  - counter=0, Rcon=RCON_INIT, key_valid=1.
  - No accept occurs that cycle. A pending out_state is neither dropped nor altered.
  - key_load asserted in the same cycle as in_valid: key_load wins and the state is not consumed.
- The next_key path is combinational from registers only; no path from in_state to the key.

Decomposition:
- AESDefinitions package: state_t, key_t (128-bit), word_t, the S-box table and a SubByte function, the RCON_INIT constant, and a GfXtime function.
- GfXtime is shared with the GaloisFieldFunctions multiply-by-2.
- One sub-module, key_schedule_step: combinational, takes (round_key, rcon) and returns next round key. It is reused by a future decryption key-expansion block.

Test Plan:
- Reset then in_valid=1 with no key -> in_ready=0 and out_valid stays 0 for 10 cycles.
- Load key 2b7e151628aed2a6abf7158809cf4f3c; send state 3243f6a8885a308d313198a2e0370734 -> one cycle later out_state=193de3bea0f4e22b9ac68d2ae9f84808, out_round=0.
- Same key; push 11 all-zero states back-to-back with out_ready=1 -> out_state equals the round keys:
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - the 12th transfer returns to round 0 = 2b7e1516....
- Hold out_ready=0 for 5 cycles with out_valid=1 -> out_state and out_round stable, in_ready=0, key does not advance; release -> next state uses the following round key.
- Pulse key_load with in_valid=1 at round 4 -> that input is not accepted; the next accepted zero state outputs the new key with out_round=0.
- Assert reset while out_valid=1 at round 7 -> out_valid=0 and key_valid=0 next cycle; in_ready=0 until key_load.
